// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake and result bus between control logic and bin_to_bcd_seq.
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   BCD;
    logic                  Neg;

    modport master (
        output Start, Bin,
        input  Busy, Done, BCD, Neg
    );

    modport slave (
        input  Start, Bin,
        output Busy, Done, BCD, Neg
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per SHIFT cycle.
// Define BCD_SIGNED_EN to treat Bin as two's complement and report the sign on Neg.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;
    logic [BW-1:0]     adj;
    logic [WIDTH-1:0]  mag;
`ifdef BCD_SIGNED_EN
    logic              sign_q, sign_d;
    logic              neg_q, neg_d;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD_SIGNED_EN
    assign mag = bus.Bin[WIDTH-1] ? (~bus.Bin + WIDTH'(1)) : bus.Bin;
`else
    assign mag = bus.Bin;
`endif

    // Add-3 correction is applied to the pre-shift digits so they never exceed 9 after the shift.
    always_comb begin
        adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
`ifdef BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    shift_d   = mag;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
`ifdef BCD_SIGNED_EN
                    sign_d    = bus.Bin[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                scratch_d = {adj[BW-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
            end
            FINISH: begin
                bcd_d  = scratch_q;
                done_d = 1'b1;
`ifdef BCD_SIGNED_EN
                neg_d  = sign_q;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
`ifdef BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    always_comb begin
        bus.Busy = (state_q != IDLE);
        bus.Done = done_q;
        bus.BCD  = bcd_q;
`ifdef BCD_SIGNED_EN
        bus.Neg  = neg_q;
`else
        bus.Neg  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int checks    = 0;
    int passed    = 0;
    int done_seen = 0;

    // Reference model: countdown of remaining busy edges plus the latched result.
    int                 m_cnt  = 0;
    int                 m_mag  = 0;
    bit                 m_sign = 1'b0;
    logic [4*DIGITS-1:0] m_bcd = '0;
    bit                 m_neg  = 1'b0;
    bit                 m_done = 1'b0;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_cnt  = 0;
            m_bcd  = '0;
            m_neg  = 1'b0;
            m_done = 1'b0;
            m_sign = 1'b0;
            m_mag  = 0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (bus.Start) begin
                    m_mag  = int'(bus.Bin);
                    m_sign = 1'b0;
`ifdef BCD_SIGNED_EN
                    if (bus.Bin[WIDTH-1]) begin
                        m_sign = 1'b1;
                        m_mag  = (1 << WIDTH) - int'(bus.Bin);
                    end
`endif
                    m_cnt = WIDTH + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_bcd  = to_bcd(m_mag);
                    m_neg  = m_sign;
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset_n) begin
            check("busy", 32'(bus.Busy), 32'(m_cnt != 0));
            check("done", 32'(bus.Done), 32'(m_done));
            check("bcd",  32'(bus.BCD),  32'(m_bcd));
            check("neg",  32'(bus.Neg),  32'(m_neg));
            if (bus.Done) done_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (!bus.Done && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 32'(bus.Done), 32'd1);
    endtask

    task automatic pulse_start(input logic [WIDTH-1:0] v);
        bus.Bin   = v;
        bus.Start = 1'b1;
        tick(1);
        bus.Start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.Start = 1'b0;
        bus.Bin   = '0;
        tick(2);
        Reset_n = 1'b1;
        tick(2);

        // Unsigned maximum, busy length measured directly
        pulse_start(9'h1FF);
        n = 0;
        while (bus.Busy && n < 50) begin
            n++;
            tick(1);
        end
        check("busy_len", 32'(n), 32'd10);
        check("max_done", 32'(bus.Done), 32'd1);
`ifdef BCD_SIGNED_EN
        check("max_bcd", 32'(bus.BCD), 32'h001);
        check("max_model", 32'(m_bcd), 32'h001);
        check("max_neg", 32'(bus.Neg), 32'd1);
`else
        check("max_bcd", 32'(bus.BCD), 32'h511);
        check("max_model", 32'(m_bcd), 32'h511);
`endif

        // Asynchronous reset in idle
        tick(2);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_bcd",  32'(bus.BCD),  32'h000);
        check("rst_neg",  32'(bus.Neg),  32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_done", 32'(bus.Done), 32'd0);
        tick(1);
        Reset_n = 1'b1;
        tick(1);

        // Zero with an ignored second Start
        pulse_start(9'h000);
        done_seen = 0;
        tick(3);
        pulse_start(9'h0FF);
        bus.Bin = '0;
        tick(12);
        check("zero_single_done", 32'(done_seen), 32'd1);
        check("zero_bcd", 32'(bus.BCD), 32'h000);
        check("zero_idle", 32'(bus.Busy), 32'd0);

        // Back-to-back with Start held high
        bus.Bin   = 9'h07B;
        bus.Start = 1'b1;
        wait_done(30, "b2b_first_done");
        check("b2b_first_bcd", 32'(bus.BCD), 32'h123);
        check("b2b_model", 32'(m_bcd), 32'h123);
        bus.Bin = 9'h100;
        tick(1);
        wait_done(30, "b2b_second_done");
        check("b2b_second_bcd", 32'(bus.BCD), 32'h256);
`ifdef BCD_SIGNED_EN
        check("b2b_second_neg", 32'(bus.Neg), 32'd1);
`endif
        bus.Start = 1'b0;
        tick(15);

        // Reset during a conversion
        pulse_start(9'h1F6);
        done_seen = 0;
        tick(5);
        Reset_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bus.BCD), 32'h000);
        check("abort_busy", 32'(bus.Busy), 32'd0);
        tick(2);
        Reset_n = 1'b1;
        tick(15);
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_bcd_after", 32'(bus.BCD), 32'h000);

        // 0x1F6 in the active interpretation
        pulse_start(9'h1F6);
        wait_done(30, "x1f6_done");
`ifdef BCD_SIGNED_EN
        check("x1f6_bcd", 32'(bus.BCD), 32'h010);
        check("x1f6_neg", 32'(bus.Neg), 32'd1);
`else
        check("x1f6_bcd", 32'(bus.BCD), 32'h502);
        check("x1f6_neg", 32'(bus.Neg), 32'd0);
`endif
        tick(2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                Reset_n = 1'b0;
                tick(1);
                Reset_n = 1'b1;
            end
            bus.Start = ($urandom_range(0, 3) == 0);
            bus.Bin   = WIDTH'($urandom);
            tick(1);
        end
        bus.Start = 1'b0;
        tick(15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
